// File: rtl/imem_refill_responder.sv
// Main-memory side of the instruction-cache refill path: accepts a line request, waits a
// fixed latency, then streams the line critical-word-first from a preloadable backing store.
module imem_refill_responder #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned MEM_AW     = 10,
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LATENCY    = 8,
    localparam int unsigned WORD_W    = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [WORD_W-1:0] rsp_word,
    output logic              rsp_last,
    output logic              busy,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);

    localparam int unsigned DEPTH  = 1 << MEM_AW;
    localparam int unsigned LINE_W = MEM_AW - WORD_W;
    localparam int unsigned WAIT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_BURST
    } state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [WORD_W-1:0] beat_q, beat_d;
    logic [LINE_W-1:0] line_q, line_d;
    logic [WORD_W-1:0] crit_q, crit_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [WORD_W-1:0] rsp_word_q, rsp_word_d;
    logic              rsp_last_q, rsp_last_d;
    logic              busy_q, busy_d;
    logic              rd_en;
    logic [WORD_W-1:0] rd_word;
    logic              unused_addr_bits;

    // Address bits above the backing-store depth alias and are intentionally dropped.
    assign unused_addr_bits = ^{req_addr[ADDR_W-1:MEM_AW], ld_addr[ADDR_W-1:MEM_AW]};

    assign req_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_word  = rsp_word_q;
    assign rsp_last  = rsp_last_q;
    assign busy      = busy_q;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        beat_d      = beat_q;
        line_d      = line_q;
        crit_d      = crit_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_word_d  = rsp_word_q;
        rsp_last_d  = 1'b0;
        rd_en       = 1'b0;
        rd_word     = crit_q + beat_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    state_d = S_WAIT;
                    line_d  = req_addr[MEM_AW-1:WORD_W];
                    crit_d  = req_addr[WORD_W-1:0];
                    beat_d  = '0;
                    wait_d  = WAIT_W'(LATENCY - 1);
                end
            end
            S_WAIT: begin
                if (wait_q == '0) begin
                    rd_en   = 1'b1;
                    state_d = S_BURST;
                end else begin
                    wait_d = wait_q - WAIT_W'(1);
                end
            end
            S_BURST: begin
                // Read one beat ahead of presentation; stop once the last beat is out.
                if (rsp_last_q) begin
                    state_d = S_IDLE;
                end else begin
                    rd_en = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (rd_en) begin
            rsp_valid_d = 1'b1;
            rsp_word_d  = rd_word;
            rsp_data_d  = mem_q[{line_q, rd_word}];
            rsp_last_d  = (beat_q == WORD_W'(LINE_WORDS - 1));
            beat_d      = beat_q + WORD_W'(1);
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            wait_q      <= '0;
            beat_q      <= '0;
            line_q      <= '0;
            crit_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_word_q  <= '0;
            rsp_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            beat_q      <= beat_d;
            line_q      <= line_d;
            crit_q      <= crit_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_word_q  <= rsp_word_d;
            rsp_last_q  <= rsp_last_d;
            busy_q      <= busy_d;
        end
    end

    // Backing store is never reset; a same-edge write is not visible to the read above.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem_q[ld_addr[MEM_AW-1:0]] <= ld_data;
        end
    end

endmodule

// File: tb/tb_imem_refill_responder.sv
// Self-checking bench for imem_refill_responder: directed line scenarios plus random
// requests compared against a word-array model of the backing store.
module tb_imem_refill_responder;

    localparam int unsigned L  = 8;
    localparam int unsigned LW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_addr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic [1:0]  rsp_word;
    logic        rsp_last;
    logic        busy;
    logic        ld_en;
    logic [15:0] ld_addr;
    logic [15:0] ld_data;

    logic [15:0] ref_mem [1024];
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    imem_refill_responder #(
        .DATA_W(16), .ADDR_W(16), .MEM_AW(10), .LINE_WORDS(LW), .LATENCY(L)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_word(rsp_word),
        .rsp_last(rsp_last), .busy(busy),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [15:0] a, input logic [15:0] d);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 1'b0;
        ref_mem[a[9:0]] = d;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b0; ld_en = 1'b0; req_addr = '0; ld_addr = '0; ld_data = '0;
        tick(); tick();
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (rsp_data !== 16'h0) begin errors++; $display("FAIL reset rsp_data got %h exp 0000", rsp_data); end
        checks++; if (rsp_word !== 2'd0) begin errors++; $display("FAIL reset rsp_word got %0d exp 0", rsp_word); end
        checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL reset rsp_last got %b exp 0", rsp_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy got %b exp 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset req_ready got %b exp 1", req_ready); end
        rst_n = 1'b1;
        tick();
    endtask

    // Full request from IDLE: cycle c is sampled just after the c-th edge past the accept edge.
    task automatic test_line(input logic [15:0] addr, input string name);
        logic [9:0]  base;
        logic [1:0]  crit, w;
        logic [15:0] exp_d, last_d;
        logic        exp_v, exp_busy, exp_rdy;
        int          b;
        base = addr[9:0] & 10'h3FC;
        crit = addr[1:0];
        last_d = '0;
        req_valid = 1'b1; req_addr = addr;
        for (int c = 0; c <= int'(L + LW); c++) begin
            tick();
            if (c == 0) req_valid = 1'b0;
            exp_v    = (c >= int'(L)) && (c < int'(L + LW));
            exp_busy = (c < int'(L + LW));
            exp_rdy  = (c >= int'(L + LW));
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL %s rsp_valid c=%0d got %b exp %b", name, c, rsp_valid, exp_v); end
            checks++; if (busy !== exp_busy) begin errors++; $display("FAIL %s busy c=%0d got %b exp %b", name, c, busy, exp_busy); end
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL %s req_ready c=%0d got %b exp %b", name, c, req_ready, exp_rdy); end
            if (exp_v) begin
                b = c - int'(L);
                w = 2'((int'(crit) + b) % int'(LW));
                exp_d = ref_mem[base + 10'(w)];
                last_d = exp_d;
                checks++; if (rsp_word !== w) begin errors++; $display("FAIL %s rsp_word beat=%0d got %0d exp %0d", name, b, rsp_word, w); end
                checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL %s rsp_data beat=%0d got %h exp %h", name, b, rsp_data, exp_d); end
                checks++; if (rsp_last !== (b == int'(LW) - 1)) begin errors++; $display("FAIL %s rsp_last beat=%0d got %b", name, b, rsp_last); end
            end else if (c == int'(L + LW)) begin
                checks++; if (rsp_data !== last_d) begin errors++; $display("FAIL %s rsp_data hold got %h exp %h", name, rsp_data, last_d); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int          acc2;
        logic        in1, in2, exp_v, exp_rdy;
        logic [1:0]  w;
        logic [9:0]  base;
        logic [15:0] exp_d;
        acc2 = int'(L + LW) + 1;
        req_valid = 1'b1; req_addr = 16'h0040;
        for (int c = 0; c <= acc2 + int'(L + LW); c++) begin
            tick();
            if (c == 0) req_addr = 16'h0080;
            if (c == acc2) req_valid = 1'b0;
            in1 = (c >= int'(L)) && (c < int'(L + LW));
            in2 = (c >= acc2 + int'(L)) && (c < acc2 + int'(L + LW));
            exp_v = in1 | in2;
            exp_rdy = (c == int'(L + LW)) || (c >= acc2 + int'(L + LW));
            checks++; if (rsp_valid !== exp_v) begin errors++; $display("FAIL b2b rsp_valid c=%0d got %b exp %b", c, rsp_valid, exp_v); end
            checks++; if (req_ready !== exp_rdy) begin errors++; $display("FAIL b2b req_ready c=%0d got %b exp %b", c, req_ready, exp_rdy); end
            if (exp_v) begin
                w = in1 ? 2'(c - int'(L)) : 2'(c - acc2 - int'(L));
                base = in1 ? 10'h040 : 10'h080;
                exp_d = ref_mem[base + 10'(w)];
                checks++; if (rsp_word !== w) begin errors++; $display("FAIL b2b rsp_word c=%0d got %0d exp %0d", c, rsp_word, w); end
                checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL b2b rsp_data c=%0d got %h exp %h", c, rsp_data, exp_d); end
            end
        end
    endtask

    task automatic test_preload_during_wait();
        logic [15:0] exp_d;
        // Write lands during WAIT, well before beat 3's read: new data expected.
        req_valid = 1'b1; req_addr = 16'h0040;
        for (int c = 0; c <= int'(L + LW); c++) begin
            tick();
            if (c == 0) req_valid = 1'b0;
            if (c == 2) begin ld_en = 1'b1; ld_addr = 16'h0043; ld_data = 16'hBEEF; end
            if (c == 3) begin ld_en = 1'b0; ref_mem[10'h043] = 16'hBEEF; end
            if (c >= int'(L) && c < int'(L + LW)) begin
                exp_d = ref_mem[10'h040 + 10'(c - int'(L))];
                checks++; if (rsp_data !== exp_d) begin errors++; $display("FAIL preload_wait rsp_data c=%0d got %h exp %h", c, rsp_data, exp_d); end
            end
            if (c == int'(L) + 3) begin
                checks++; if (rsp_data !== 16'hBEEF) begin errors++; $display("FAIL preload_wait beat3 got %h exp beef", rsp_data); end
            end
        end
        // Write in the same cycle beat 3 is read: old data expected.
        req_valid = 1'b1; req_addr = 16'h0040;
        for (int c = 0; c <= int'(L + LW); c++) begin
            tick();
            if (c == 0) req_valid = 1'b0;
            if (c == int'(L) + 2) begin ld_en = 1'b1; ld_addr = 16'h0043; ld_data = 16'h5A5A; end
            if (c == int'(L) + 3) begin
                ld_en = 1'b0;
                checks++; if (rsp_data !== 16'hBEEF) begin errors++; $display("FAIL preload_same rsp_data got %h exp beef", rsp_data); end
                ref_mem[10'h043] = 16'h5A5A;
            end
        end
        test_line(16'h0040, "preload_after");
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_addr = 16'h0040;
        for (int c = 0; c <= int'(L) + 1; c++) begin
            tick();
            if (c == 0) req_valid = 1'b0;
        end
        checks++; if (rsp_valid !== 1'b1 || rsp_word !== 2'd1) begin errors++; $display("FAIL rst_mid beat1 got v=%b w=%0d exp v=1 w=1", rsp_valid, rsp_word); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_mid rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid busy got %b exp 0", busy); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_mid req_ready got %b exp 1", req_ready); end
        checks++; if (rsp_data !== 16'h0 || rsp_word !== 2'd0 || rsp_last !== 1'b0) begin errors++; $display("FAIL rst_mid rsp fields got d=%h w=%0d l=%b exp 0", rsp_data, rsp_word, rsp_last); end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid stale beat c=%0d got v=%b busy=%b exp 0", c, rsp_valid, busy); end
        end
        test_line(16'h0040, "rst_rerequest");
    endtask

    task automatic test_random();
        logic [15:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                load({a[15:2], 2'($urandom)} ^ 16'($urandom_range(0, 1) << 12), 16'($urandom));
            test_line(a, "random");
        end
    endtask

    initial begin
        test_reset();
        for (int i = 0; i < 1024; i++) load(16'(i), 16'($urandom));
        load(16'h0040, 16'hA000);
        load(16'h0041, 16'hA001);
        load(16'h0042, 16'hA002);
        load(16'h0043, 16'hA003);
        test_line(16'h0040, "basic");
        test_line(16'h0042, "critical");
        test_line(16'h0043, "crit_last");
        test_back_to_back();
        test_preload_during_wait();
        load(16'h0043, 16'hA003);
        test_line(16'h0440, "alias");
        test_line(16'hFC41, "alias_hi");
        test_line(16'h03FE, "top_line");
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
